// File: rtl/cursor_trail_buffer.sv
// Purpose: ring buffer of recent on-screen cursor samples, hit-tested against the VGA scan point.
// Latency: trail_hit/trail_age are registered, one Clk after DrawX/DrawY; a write joins the test the edge after it lands.
// Backpressure: none; one hit result per Clk, samples are taken on frame ticks and never stalled.
//
// Ports: Clk/Reset (async, active-high); vs frame sync (active low); clear empties the trail;
//        cursorX/cursorY sample source; DrawX/DrawY scan point; trail_hit/trail_age hit result;
//        entry_count number of valid entries.
// Optional feature: define CURSOR_TRAIL_DEDUP_EN to skip samples equal to the newest valid entry.
module cursor_trail_buffer #(
  parameter int DEPTH      = 8,
  parameter int RADIUS     = 2,
  parameter int SAMPLE_DIV = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       vs,
  input  logic                       clear,
  input  logic [9:0]                 cursorX,
  input  logic [9:0]                 cursorY,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  output logic                       trail_hit,
  output logic [$clog2(DEPTH)-1:0]   trail_age,
  output logic [$clog2(DEPTH):0]     entry_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          vs_q,     vs_d;
  logic [3:0]    div_cnt_q, div_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [9:0]    mem_x_q [DEPTH];
  logic [9:0]    mem_y_q [DEPTH];
  logic [9:0]    mem_x_d [DEPTH];
  logic [9:0]    mem_y_d [DEPTH];
  logic          hit_q,    hit_d;
  logic [AW-1:0] age_q,    age_d;

  logic          tick;
  logic          sample;
  logic          on_screen;
  logic          is_dup;
  logic          do_write;

  // Per-entry hit test results
  logic          ent_hit [DEPTH];
  logic [AW-1:0] ent_age [DEPTH];

  assign tick      = vs_q & ~vs;
  assign sample    = tick && (div_cnt_q == 4'(SAMPLE_DIV - 1));
  assign on_screen = (cursorX < 10'd640) && (cursorY < 10'd480);

`ifdef CURSOR_TRAIL_DEDUP_EN
  logic [AW-1:0] newest_idx;
  assign newest_idx = wr_ptr_q - AW'(1);
  // An empty buffer never counts as a duplicate, whatever stale data sits in mem.
  assign is_dup = (count_q != '0) &&
                  (mem_x_q[newest_idx] == cursorX) &&
                  (mem_y_q[newest_idx] == cursorY);
`else
  assign is_dup = 1'b0;
`endif

  // clear beats a coincident sample
  assign do_write = sample && on_screen && !is_dup && !clear;

  // Frame divider, pointer, count and storage
  always_comb begin
    vs_d      = vs;
    div_cnt_d = div_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_x_d[i] = mem_x_q[i];
      mem_y_d[i] = mem_y_q[i];
    end

    // The divider keeps running through clears and dropped samples.
    if (tick) begin
      if (div_cnt_q == 4'(SAMPLE_DIV - 1)) div_cnt_d = '0;
      else                                 div_cnt_d = div_cnt_q + 4'd1;
    end

    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (do_write) begin
      mem_x_d[wr_ptr_q] = cursorX;
      mem_y_d[wr_ptr_q] = cursorY;
      wr_ptr_d          = wr_ptr_q + AW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end
  end

  // Hit test against every valid entry
  always_comb begin
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic        [10:0] adx;
    logic        [10:0] ady;
    for (int i = 0; i < DEPTH; i++) begin
      // Entry i was written (wr_ptr - 1 - i) samples ago; the AW-bit wrap is the mod DEPTH.
      ent_age[i] = wr_ptr_q - AW'(1) - AW'(i);
      dx  = $signed({1'b0, DrawX}) - $signed({1'b0, mem_x_q[i]});
      dy  = $signed({1'b0, DrawY}) - $signed({1'b0, mem_y_q[i]});
      adx = dx[10] ? 11'(-dx) : 11'(dx);
      ady = dy[10] ? 11'(-dy) : 11'(dy);
      ent_hit[i] = ({1'b0, ent_age[i]} < count_q) &&
                   (adx <= 11'(RADIUS)) && (ady <= 11'(RADIUS));
    end
  end

  // Youngest hit wins; age reads 0 when nothing hits.
  always_comb begin
    hit_d = 1'b0;
    age_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_hit[i] && (!hit_d || ent_age[i] < age_d)) begin
        hit_d = 1'b1;
        age_d = ent_age[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q      <= 1'b1;
      div_cnt_q <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      age_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_x_q[i] <= '0;
        mem_y_q[i] <= '0;
      end
    end else begin
      vs_q      <= vs_d;
      div_cnt_q <= div_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      hit_q     <= hit_d;
      age_q     <= age_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_x_q[i] <= mem_x_d[i];
        mem_y_q[i] <= mem_y_d[i];
      end
    end
  end

  assign trail_hit   = hit_q;
  assign trail_age   = age_q;
  assign entry_count = count_q;

endmodule

// File: tb/tb_cursor_trail_buffer.sv
// Bench for cursor_trail_buffer: two instances (SAMPLE_DIV 2 and 1) share all inputs.
// A newest-first history array per instance predicts hit/age/count every cycle.
module tb_cursor_trail_buffer;

  localparam int DEPTH  = 8;
  localparam int RADIUS = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       vs    = 1'b1;
  logic       clear = 1'b0;
  logic [9:0] cx = '0, cy = '0, dx = '0, dy = '0;

  logic       a_hit, b_hit;
  logic [2:0] a_age, b_age;
  logic [3:0] a_cnt, b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  cursor_trail_buffer #(.DEPTH(DEPTH), .RADIUS(RADIUS), .SAMPLE_DIV(2)) dut_a (
    .Clk(clk), .Reset(rst), .vs(vs), .clear(clear),
    .cursorX(cx), .cursorY(cy), .DrawX(dx), .DrawY(dy),
    .trail_hit(a_hit), .trail_age(a_age), .entry_count(a_cnt)
  );

  cursor_trail_buffer #(.DEPTH(DEPTH), .RADIUS(RADIUS), .SAMPLE_DIV(1)) dut_b (
    .Clk(clk), .Reset(rst), .vs(vs), .clear(clear),
    .cursorX(cx), .cursorY(cy), .DrawX(dx), .DrawY(dy),
    .trail_hit(b_hit), .trail_age(b_age), .entry_count(b_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   sd [2] = '{2, 1};
  int   hx [2][DEPTH];       // index = age, 0 newest
  int   hy [2][DEPTH];
  int   hsize  [2] = '{0, 0};
  int   frames [2] = '{0, 0};
  bit   vs_prev = 1'b1;
  bit   m_tick;
  bit   m_dup;
  bit   exp_hit [2] = '{0, 0};
  int   exp_age [2] = '{0, 0};
  int   exp_cnt [2] = '{0, 0};

  function automatic bit near(input int px, input int py, input int x, input int y);
    int ax, ay;
    ax = px - x; if (ax < 0) ax = -ax;
    ay = py - y; if (ay < 0) ay = -ay;
    return (ax <= RADIUS) && (ay <= RADIUS);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev = 1'b1;
      for (int m = 0; m < 2; m++) begin
        hsize[m] = 0; frames[m] = 0;
        exp_hit[m] = 0; exp_age[m] = 0; exp_cnt[m] = 0;
      end
    end else begin
      m_tick  = vs_prev && !vs;
      vs_prev = vs;
      for (int m = 0; m < 2; m++) begin
        // result from the state seen at this edge
        exp_hit[m] = 0; exp_age[m] = 0;
        for (int a = hsize[m] - 1; a >= 0; a--) begin
          if (near(int'(dx), int'(dy), hx[m][a], hy[m][a])) begin
            exp_hit[m] = 1; exp_age[m] = a;
          end
        end
        if (m_tick) begin
          frames[m]++;
`ifdef CURSOR_TRAIL_DEDUP_EN
          m_dup = (hsize[m] > 0) && (hx[m][0] == int'(cx)) && (hy[m][0] == int'(cy));
`else
          m_dup = 0;
`endif
          if ((frames[m] % sd[m] == 0) && !clear && cx < 640 && cy < 480 && !m_dup) begin
            for (int a = DEPTH - 1; a > 0; a--) begin
              hx[m][a] = hx[m][a-1]; hy[m][a] = hy[m][a-1];
            end
            hx[m][0] = int'(cx); hy[m][0] = int'(cy);
            if (hsize[m] < DEPTH) hsize[m]++;
          end
        end
        if (clear) hsize[m] = 0;
        exp_cnt[m] = hsize[m];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("hit_a", int'(a_hit), int'(exp_hit[0]));
    check("age_a", int'(a_age), exp_age[0]);
    check("cnt_a", int'(a_cnt), exp_cnt[0]);
    check("hit_b", int'(b_hit), int'(exp_hit[1]));
    check("age_b", int'(b_age), exp_age[1]);
    check("cnt_b", int'(b_cnt), exp_cnt[1]);
  end

  // ---------------- stimulus ----------------
  task automatic frame(input logic clr);
    vs = 1'b0; clear = clr;
    @(negedge clk);
    vs = 1'b1; clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input int x, input int y);
    dx = 10'(x); dy = 10'(y);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset with vs toggling
    for (int i = 0; i < 10; i++) begin
      vs = 1'($urandom_range(0, 1));
      dx = 10'($urandom_range(0, 639)); dy = 10'($urandom_range(0, 479));
      @(negedge clk);
      check("reset_hit_b", int'(b_hit), 0);
      check("reset_cnt_a", int'(a_cnt), 0);
    end
    vs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single sample on the SAMPLE_DIV=2 instance
    cx = 10'd100; cy = 10'd50;
    frame(1'b0);
    check("single_cnt_after_1st_tick", int'(a_cnt), 0);
    frame(1'b0);
    check("single_cnt", int'(a_cnt), 1);
    probe(102, 48);
    check("single_hit", int'(a_hit), 1);
    check("single_age", int'(a_age), 0);
    check("single_model_hit", int'(exp_hit[0]), 1);
    probe(103, 50);
    check("single_miss", int'(a_hit), 0);

    // Wrap-around on the SAMPLE_DIV=1 instance
    pulse_clear();
    for (int k = 1; k <= 10; k++) begin
      cx = 10'(10 * k); cy = 10'd200;
      frame(1'b0);
    end
    check("wrap_cnt", int'(b_cnt), 8);
    probe(30, 200);
    check("wrap_hit30", int'(b_hit), 1);
    check("wrap_age30", int'(b_age), 7);
    check("wrap_model_age30", exp_age[1], 7);
    probe(20, 200);
    check("wrap_miss20", int'(b_hit), 0);
    probe(10, 200);
    check("wrap_miss10", int'(b_hit), 0);
    probe(100, 200);
    check("wrap_hit100", int'(b_hit), 1);
    check("wrap_age100", int'(b_age), 0);

    // Overlap: youngest hit wins
    pulse_clear();
    cx = 10'd50; cy = 10'd50; frame(1'b0);
    cx = 10'd51;              frame(1'b0);
    probe(50, 50);
    check("overlap_hit", int'(b_hit), 1);
    check("overlap_age", int'(b_age), 0);

    // Clear coinciding with a sample tick, then off-screen cursor
    cx = 10'd400; cy = 10'd400;
    frame(1'b1);
    check("clear_cnt", int'(b_cnt), 0);
    probe(400, 400);
    check("clear_nohit", int'(b_hit), 0);
    cx = 10'd640; cy = 10'd10;
    frame(1'b0);
    check("offscreen_cnt", int'(b_cnt), 0);

    // Stationary cursor
    cx = 10'd300; cy = 10'd300;
    for (int k = 0; k < 4; k++) frame(1'b0);
`ifdef CURSOR_TRAIL_DEDUP_EN
    check("dedup_cnt", int'(b_cnt), 1);
`else
    check("dedup_cnt", int'(b_cnt), 4);
`endif

    // Randomized traffic in a small window plus edge cases, with one mid-frame reset
    for (int i = 0; i < 3000; i++) begin
      vs    = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      clear = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          cx = 10'($urandom_range(630, 700)); cy = 10'($urandom_range(470, 520));
        end else begin
          cx = 10'($urandom_range(0, 40)); cy = 10'($urandom_range(0, 40));
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        dx = 10'($urandom_range(620, 1023)); dy = 10'($urandom_range(460, 1023));
      end else begin
        dx = 10'($urandom_range(0, 45)); dy = 10'($urandom_range(0, 45));
      end
      if (i == 1500) begin
        #3 rst = 1'b1;
      end
      if (i == 1504) rst = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_trail_buffer.md
# cursor_trail_buffer

Ring buffer of recent cursor positions that turns the Arduino cursor feed into a per-pixel swipe trail. It sits between `arduino_fpga_comm`, which supplies `xCoordinate`/`yCoordinate`, and `frame_displayer`, which consumes `trail_hit`/`trail_age` to paint the blade trail. Once per sampled frame it stores the cursor position. Every clock it tests the current VGA scan position against all stored points and reports a registered hit.

## Interface
- `DEPTH`, 8: trail entries; power of two, 2..32.
- `RADIUS`, 2: half-width in pixels of the square dot drawn per entry; 0..15.
- `SAMPLE_DIV`, 2: store one sample every `SAMPLE_DIV` frames; 1..15.

Ports:
- `Clk`  in  1  50 MHz system clock; the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `vs`  in  1  VGA vertical sync, active low, generated in the `Clk` domain.
- `clear`  in  1  one-cycle pulse that empties the trail (streak ended).
- `cursorX`  in  10  cursor column.
- `cursorY`  in  10  cursor row.
- `DrawX`  in  10  current scan column.
- `DrawY`  in  10  current scan row.
- `trail_hit`  out  1  the scan pixel lies inside some valid entry's dot.
- `trail_age`  out  $clog2(DEPTH)  age of the youngest hit entry; 0 = newest.
- `entry_count`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation
- Frame tick:
  - `vs` is registered into `vs_q`.
  - tick = `vs_q & ~vs` (falling edge), asserted for exactly one cycle per frame.
- Frame divider: `div_cnt` counts ticks 0..SAMPLE_DIV-1 and wraps. A sample is taken on a tick where `div_cnt == SAMPLE_DIV-1`.
- Write on a sample:
  - `{cursorX, cursorY}` goes to `mem[wr_ptr]`.
  - `wr_ptr` increments modulo DEPTH.
  - `entry_count` increments and saturates at DEPTH. Once full, the oldest entry is overwritten.
- Off-screen cursor: if `cursorX >= 640` or `cursorY >= 480`, the sample is dropped. There is no write and no pointer or count change, but `div_cnt` still advances.
- Clear:
  - `entry_count` goes to 0 and `wr_ptr` goes to 0. `mem` contents are left stale but invalid.
  - `div_cnt` is not affected.
  - If `clear` and a sample occur in the same cycle, `clear` wins and no write happens.
- Age: entry i has age `(wr_ptr - 1 - i) mod DEPTH`. Only entries with age < `entry_count` are valid.
- Hit test, for each valid entry:
  - compute `|DrawX - x|` and `|DrawY - y|` using 11-bit signed subtraction, with no modular wrap at screen edges.
  - hit if both differences are <= RADIUS.
- Outputs:
  - `trail_hit` = OR of the per-entry hits.
  - `trail_age` = minimum age among hit entries, or 0 when there is no hit.
- Reset values: `trail_hit` 0, `trail_age` 0, `entry_count` 0, `wr_ptr` 0, `div_cnt` 0, `vs_q` 1.

## Timing
- `trail_hit` and `trail_age` are registered. They reflect the `DrawX`/`DrawY` and buffer state sampled at rising edge N, and are visible after edge N, i.e. 1 `Clk` of latency.
- A sample is written at the tick edge. It takes part in the hit test from the next edge onward.
- `entry_count` updates on the same edge as the write or the clear.
- Reset asserted mid-frame forces all outputs to 0 immediately and asynchronously. The first tick after release is counted as `div_cnt` 0.
- Throughput: one hit result per `Clk`. Since `pixel_clk` is `Clk`/2, each pixel is evaluated twice with identical results.

## Configuration
- `CURSOR_TRAIL_DEDUP_EN` defined: a sample exactly equal to the newest valid entry is not written. No pointer or count change occurs, so a stationary cursor does not flush the trail. An empty buffer always accepts the sample.
- Undefined: every on-screen sample is written, even if it duplicates the newest entry.

## Test plan
- **Reset:** assert Reset with `vs` toggling. Required: outputs 0, `entry_count` 0, `trail_hit` 0 at every DrawX/DrawY.
- **Single sample:** SAMPLE_DIV=2, RADIUS=2, cursor (100,50), two `vs` falling edges. Required:
  - `entry_count`=1.
  - DrawX/DrawY (102,48) → `trail_hit`=1, `trail_age`=0 one cycle later.
  - (103,50) → `trail_hit`=0.
- **Wrap-around:** DEPTH=8, SAMPLE_DIV=1, cursor x=10,20,…,100 at y=200 over 10 frames. Required:
  - `entry_count`=8.
  - (30,200) → hit with age 7.
  - (20,200) and (10,200) → no hit.
  - (100,200) → age 0.
- **Overlap:** entries at (50,50) age 1 and (51,50) age 0, DrawX/DrawY (50,50). Required: `trail_age`=0.
- **Clear and off-screen:** pulse `clear` on the same cycle as a sample tick. Required:
  - `entry_count`=0 and no hit at the new cursor.
  - then cursor (640,10) on a tick → `entry_count` stays 0.
- **Dedup:** cursor held at (300,300) for 4 sample ticks. Required: `entry_count`=1 with `CURSOR_TRAIL_DEDUP_EN` defined, 4 without.
